// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit -- instruction fetch stage for the RV32I core.
//
// Holds the architectural PC. For each instruction it issues a single
// request to instruction memory, waits for the response, and presents the
// instruction and its PC to the decoder and datapath until the datapath
// retires it. On retire, the next PC comes from the decoder's branch/jump
// selects, the immediate and the ALU result.
//
// Configuration macro: IFETCH_MISALIGN_TRAP_EN
//   defined   : a retire whose next PC is not word-aligned loads that PC and
//               parks in FAULT (fetch_fault=1, no further requests) until
//               reset.
//   undefined : next PC[1:0] is forced to 2'b00 and fetch_fault stays 0.
//
// Parameters:
//   RESET_PC   PC loaded on reset (word-aligned).
//   NOP_INSTR  value shown on Instr while no instruction is valid.
//
// Ports:
//   clk, reset              rising-edge clock, async active-high reset
//   PCSrc, PCTargetSrc      next-PC selects from the decoder
//   ImmExt, ALUResult       branch offset / jalr target operands
//   retire                  datapath has finished the current instruction
//   imem_req, imem_addr     one-cycle request pulse and its address (= PC)
//   imem_rvalid, imem_rdata instruction memory response
//   Instr, PC, PCPlus4      current instruction, its address, address+4
//   instr_valid             Instr is valid and waiting to retire
//   fetch_fault             misaligned-target trap taken
// ---------------------------------------------------------------------------
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrc,
  input  logic        PCTargetSrc,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult,
  input  logic        retire,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        instr_valid,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_EXEC  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic [31:0] w_next_pc_raw;
  logic [31:0] w_next_pc;
  logic        w_retire_now;
  logic        w_take_fault;

  assign w_retire_now = (r_state == S_EXEC) && retire;

  // Next-PC selection. All adds wrap modulo 2^32; jalr clears bit 0 as the
  // ISA requires.
  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_target      = PCTargetSrc ? {ALUResult[31:1], 1'b0} : (r_pc + ImmExt);
  assign w_next_pc_raw = PCSrc ? w_target : w_pc_plus4;

`ifdef IFETCH_MISALIGN_TRAP_EN
  // The offending PC is kept as-is so a trap handler can see it.
  assign w_next_pc    = w_next_pc_raw;
  assign w_take_fault = w_retire_now && (w_next_pc_raw[1:0] != 2'b00);
  assign fetch_fault  = (r_state == S_FAULT);
`else
  assign w_next_pc    = w_next_pc_raw & ~32'h0000_0003;
  assign w_take_fault = 1'b0;
  assign fetch_fault  = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
    end else begin
      r_state <= w_state_next;
      if ((r_state == S_WAIT) && imem_rvalid) begin
        r_instr <= imem_rdata;
      end
      if (w_retire_now) begin
        r_pc    <= w_next_pc;
        r_instr <= NOP_INSTR;
      end
    end
  end

  always_comb begin
    // NOTE: defaulting every output of this block first keeps any unlisted
    // path from holding a stale value, which would infer a latch.
    w_state_next = r_state;
    case (r_state)
      S_FETCH: w_state_next = S_WAIT;
      S_WAIT:  if (imem_rvalid) w_state_next = S_EXEC;
      S_EXEC: begin
        if (w_take_fault)      w_state_next = S_FAULT;
        else if (w_retire_now) w_state_next = S_FETCH;
      end
      S_FAULT: w_state_next = S_FAULT;
      default: w_state_next = S_FETCH;
    endcase
  end

  // The reset state is FETCH, so the request is masked while reset is held.
  assign imem_req    = (r_state == S_FETCH) && !reset;
  assign imem_addr   = r_pc;
  assign PC          = r_pc;
  assign PCPlus4     = w_pc_plus4;
  assign Instr       = r_instr;
  assign instr_valid = (r_state == S_EXEC);

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage for the RV32I core. Holds the architectural PC, issues one request per instruction to instruction memory, and presents the returned instruction and its PC to the control decoder and datapath. On each retire it computes the next PC from the decoder's `PCSrc`/`PCTargetSrc` outputs, the immediate and the ALU result.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `NOP_INSTR`, default 32'h0000_0013: value driven on `Instr` while no instruction is valid (`addi x0,x0,0`).

Ports:
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — asynchronous, active-high.
- `PCSrc`  in  1  — from decoder; 1 = redirect, 0 = sequential.
- `PCTargetSrc`  in  1  — from decoder; 0 = PC+ImmExt target, 1 = jalr target from ALU.
- `ImmExt`  in  32  — sign-extended immediate of the current instruction.
- `ALUResult`  in  32  — rs1+imm for jalr.
- `retire`  in  1  — datapath has completed the current instruction.
- `imem_req`  out  1  — one-cycle request pulse.
- `imem_addr`  out  32  — request address (= `PC`).
- `imem_rvalid`  in  1  — response valid, exactly one per request.
- `imem_rdata`  in  32  — response instruction word.
- `Instr`  out  32  — current instruction to decoder.
- `PC`  out  32  — address of `Instr`.
- `PCPlus4`  out  32  — `PC`+4, for jal/jalr link.
- `instr_valid`  out  1  — `Instr` is valid and awaiting retire.
- `fetch_fault`  out  1  — misaligned target trap (macro-dependent).

## Operation
- States: FETCH, WAIT, EXEC, FAULT.
- FETCH: `imem_req`=1 (decoded from state, not registered separately), `imem_addr`=`PC`; next state WAIT unconditionally.
- WAIT: `imem_rvalid`=1 → latch `imem_rdata` into `Instr`, set `instr_valid`, go EXEC; else stay. `imem_rvalid` in any other state is ignored.
- EXEC: hold `Instr`, `PC`, `instr_valid`=1. `retire`=1 → `PC` ← next_pc, `instr_valid` ← 0, `Instr` ← `NOP_INSTR`, go FETCH. `retire` outside EXEC is ignored.
- next_pc: `PCSrc`=0 → `PC`+4; `PCSrc`=1, `PCTargetSrc`=0 → `PC`+`ImmExt`; `PCSrc`=1, `PCTargetSrc`=1 → {`ALUResult`[31:1],1'b0}. All sums are 32-bit modulo 2^32 (0xFFFF_FFFC+4 → 0). Inputs are sampled only on the retiring edge.
- Reset (any state, any time): state FETCH, `PC`=`RESET_PC`, `Instr`=`NOP_INSTR`, `instr_valid`=0, `fetch_fault`=0. Instruction memory shares `reset`, so no stale response survives a mid-WAIT reset.
- Reset values of outputs: `imem_req`=0 during reset, `imem_addr`=`RESET_PC`, `PCPlus4`=`RESET_PC`+4.

## Timing
- `imem_req` is high in the first cycle after `reset` deasserts.
- Minimum memory latency is 1 cycle: `imem_rvalid` is earliest in the cycle after `imem_req`.
- `instr_valid` rises the cycle after `imem_rvalid` is sampled.
- Retire to next `imem_req` takes 1 cycle (the edge that samples `retire` enters FETCH).
- Zero-wait-state memory gives a 3-cycle minimum per instruction (FETCH, WAIT, EXEC).
- `PCPlus4` and `imem_addr` are combinational from the `PC` register.

## Configuration
- `IFETCH_MISALIGN_TRAP_EN` defined: a retire whose next_pc[1:0]≠0 loads that PC and enters FAULT. In FAULT, `fetch_fault`=1, `instr_valid`=0, no requests are issued, and the state holds until reset.
- `IFETCH_MISALIGN_TRAP_EN` not defined: next_pc[1:0] is forced to 2'b00, FAULT is unreachable, and `fetch_fault` is tied to 0.

## Test plan
- Reset release, memory latency 1: `imem_req`=1 with `imem_addr`=0x0 on cycle 1, `instr_valid`=1 with `Instr`=rdata on cycle 3.
- Sequential run, `PCSrc`=0, retire each instruction: addresses 0x0, 0x4, 0x8. With memory latency 3, `instr_valid` is delayed by exactly 2 cycles per fetch.
- Branch: `PC`=0x100, `PCSrc`=1, `PCTargetSrc`=0, `ImmExt`=0xFFFF_FFF0 → next `imem_addr`=0xF0. `ImmExt`=0x10 at `PC`=0xFFFF_FFF8 → wraps to 0x8.
- jalr: `PCTargetSrc`=1, `ALUResult`=0x0000_2005 → next `imem_addr`=0x2004, `PCPlus4` of the jalr instruction unchanged during EXEC.
- Misaligned target 0x2006: with macro, `fetch_fault`=1 and no further `imem_req`. Without macro, fetch from 0x2004.
- `reset` asserted mid-WAIT and again mid-EXEC → outputs immediately return to reset values, and the next `imem_req` is at `RESET_PC`. `retire` pulses during FETCH/WAIT leave `PC` unchanged.
